// File: rtl/dequant_pkg.sv
// Shared types and band tables for the dequantizer sequencing controller.
package dequant_pkg;

  localparam int DQ_N_COEF = 576;
  localparam int DQ_N_SFB  = 22;
  localparam int DQ_IS_W   = 16;
  localparam int DQ_EXP_W  = 10;
  localparam int GAIN_BIAS = 210;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_SF,
    SF_WAIT,
    RUN,
    DRAIN
  } state_t;

  // One queued output entry; the exponent travels with its coefficient.
  typedef struct packed {
    logic signed [DQ_IS_W-1:0]  is;
    logic signed [DQ_EXP_W-1:0] exp;
    logic [4:0]                 sfb;
    logic                       last;
  } dq_entry_t;

  // Exclusive end index of each long-block scalefactor band.
  localparam logic [9:0] SFB_END [DQ_N_SFB] = '{
    10'd4,   10'd8,   10'd12,  10'd16,  10'd20,  10'd24,  10'd30,  10'd36,
    10'd44,  10'd52,  10'd62,  10'd74,  10'd90,  10'd110, 10'd134, 10'd162,
    10'd196, 10'd238, 10'd288, 10'd342, 10'd418, 10'd576
  };

  // Pre-emphasis added to the scalefactor when preflag is set.
  localparam logic [1:0] PRETAB [DQ_N_SFB] = '{
    2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
    2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd2, 2'd0
  };

endpackage

// File: rtl/dequant_ctrl_skid.sv
// Two-entry valid/ready buffer for dequantizer entries; reports occupancy.
module dequant_ctrl_skid
  import dequant_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  dq_entry_t  in_data,
  output logic       out_valid,
  output dq_entry_t  out_data,
  input  logic       out_ready,
  output logic [1:0] count
);

  dq_entry_t mem [2];
  logic      wr_ptr;
  logic      rd_ptr;
  logic      push;
  logic      pop;

  // Head of queue is presented straight from storage, so it holds while stalled.
  always_comb begin
    out_valid = (count != 2'd0);
    out_data  = mem[rd_ptr];
    pop       = out_valid && out_ready;
    push      = in_valid && ((count != 2'd2) || pop);
  end

  // Storage, pointers and occupancy; reset empties the queue and zeroes the head.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/dequant_ctrl.sv
// Walks one granule band by band, fetching scalefactors and coefficients and
// streaming {is, exp} entries to the dequantizer under back-pressure.
module dequant_ctrl
  import dequant_pkg::*;
#(
  parameter int N_COEF = DQ_N_COEF,
  parameter int N_SFB  = DQ_N_SFB,
  parameter int IS_W   = DQ_IS_W,
  parameter int EXP_W  = DQ_EXP_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [7:0]              global_gain,
  input  logic                    scalefac_scale,
  input  logic                    preflag,
  output logic                    busy,
  output logic                    done,
  output logic                    sf_ren,
  output logic [4:0]              sf_raddr,
  input  logic [3:0]              sf_rdata,
  output logic                    coef_ren,
  output logic [9:0]              coef_raddr,
  input  logic signed [IS_W-1:0]  coef_rdata,
  output logic                    dq_valid,
  input  logic                    dq_ready,
  output logic signed [IS_W-1:0]  dq_is,
  output logic signed [EXP_W-1:0] dq_exp,
  output logic [4:0]              dq_sfb,
  output logic                    dq_last
);

  state_t           state;
  state_t           state_nxt;
  logic [4:0]       sfb;
  logic [9:0]       idx;
  logic [9:0]       idx_inc;
  logic [7:0]       gain_q;
  logic             scale_q;
  logic             pre_q;
  logic [EXP_W-1:0] exp_q;
  logic [EXP_W-1:0] exp_calc;
  logic [4:0]       sf_eff;
  logic [6:0]       sf_shift;
  logic             rd_pending;
  logic [EXP_W-1:0] rd_exp;
  logic [4:0]       rd_sfb;
  logic             rd_last;
  logic             issue;
  logic             band_end;
  logic             last_band;
  logic             pop;
  logic             room;
  logic             done_q;
  logic [1:0]       skid_count;
  logic [2:0]       occupancy;
  logic             head_valid;
  dq_entry_t        wr_entry;
  dq_entry_t        head;

  // Band bookkeeping, gain exponent and read-credit arithmetic.
  always_comb begin
    idx_inc   = idx + 10'd1;
    band_end  = (idx_inc == SFB_END[sfb]);
    last_band = (sfb == 5'(N_SFB - 1));
    sf_eff    = 5'd0;
    if (!last_band) begin
      sf_eff = {1'b0, sf_rdata} + (pre_q ? {3'b000, PRETAB[sfb]} : 5'd0);
    end
    sf_shift  = scale_q ? {sf_eff, 2'b00} : {1'b0, sf_eff, 1'b0};
    exp_calc  = EXP_W'({2'b00, gain_q}) - EXP_W'(GAIN_BIAS) - EXP_W'(sf_shift);
    pop       = head_valid && dq_ready;
    occupancy = {1'b0, skid_count} + {2'b00, rd_pending} - {2'b00, pop};
    room      = (occupancy < 3'd2);
    wr_entry.is   = coef_rdata;
    wr_entry.exp  = rd_exp;
    wr_entry.sfb  = rd_sfb;
    wr_entry.last = rd_last;
  end

  // Next-state logic and memory read strobes.
  always_comb begin
    state_nxt  = state;
    sf_ren     = 1'b0;
    sf_raddr   = 5'd0;
    coef_ren   = 1'b0;
    coef_raddr = 10'd0;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD_SF;
        end
      end
      LOAD_SF: begin
        sf_ren    = 1'b1;
        sf_raddr  = sfb;
        state_nxt = SF_WAIT;
      end
      SF_WAIT: begin
        state_nxt = RUN;
      end
      RUN: begin
        if (room) begin
          coef_ren   = 1'b1;
          coef_raddr = idx;
          issue      = 1'b1;
          if (band_end) begin
            state_nxt = last_band ? DRAIN : LOAD_SF;
          end
        end
      end
      DRAIN: begin
        if (pop && head.last) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Configuration latch, band/coefficient counters, exponent and done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sfb     <= 5'd0;
      idx     <= 10'd0;
      gain_q  <= 8'd0;
      scale_q <= 1'b0;
      pre_q   <= 1'b0;
      exp_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state == DRAIN) && pop && head.last;
      if (state == IDLE && start) begin
        gain_q  <= global_gain;
        scale_q <= scalefac_scale;
        pre_q   <= preflag;
        sfb     <= 5'd0;
        idx     <= 10'd0;
      end
      if (state == SF_WAIT) begin
        exp_q <= exp_calc;
      end
      if (issue) begin
        idx <= idx_inc;
        if (band_end && !last_band) begin
          sfb <= sfb + 5'd1;
        end
      end
    end
  end

  // Tag each coefficient read with its exponent, band and last flag until data returns.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_pending <= 1'b0;
      rd_exp     <= '0;
      rd_sfb     <= 5'd0;
      rd_last    <= 1'b0;
    end else begin
      rd_pending <= issue;
      if (issue) begin
        rd_exp  <= exp_q;
        rd_sfb  <= sfb;
        rd_last <= (idx == 10'(N_COEF - 1));
      end
    end
  end

  dequant_ctrl_skid u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_pending),
    .in_data   (wr_entry),
    .out_valid (head_valid),
    .out_data  (head),
    .out_ready (dq_ready),
    .count     (skid_count)
  );

  assign busy     = (state != IDLE);
  assign done     = done_q;
  assign dq_valid = head_valid;
  assign dq_is    = head.is;
  assign dq_exp   = head.exp;
  assign dq_sfb   = head.sfb;
  assign dq_last  = head_valid && head.last;

endmodule

// File: tb/tb_dequant_ctrl.sv
// Self-checking bench for dequant_ctrl: table of granule configurations plus
// hand-written stall, start-while-busy and mid-granule reset sequences.
module tb_dequant_ctrl;

  localparam int NC = 576;
  localparam int NB = 22;

  typedef struct {
    int gg;
    bit ss;
    bit pre;
    int sfmode;
    int rmode;
    int pct;
    int exp_band;
    int exp_val;
    bit timing;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        global_gain = 8'd0;
  logic              scalefac_scale = 1'b0;
  logic              preflag = 1'b0;
  logic              busy;
  logic              done;
  logic              sf_ren;
  logic [4:0]        sf_raddr;
  logic [3:0]        sf_rdata = 4'd0;
  logic              coef_ren;
  logic [9:0]        coef_raddr;
  logic signed [15:0] coef_rdata = 16'sd0;
  logic              dq_valid;
  logic              dq_ready = 1'b1;
  logic signed [15:0] dq_is;
  logic signed [9:0] dq_exp;
  logic [4:0]        dq_sfb;
  logic              dq_last;

  int checks = 0;
  int errors = 0;

  int sfb_end_t [NB] = '{4, 8, 12, 16, 20, 24, 30, 36, 44, 52, 62, 74, 90, 110,
                         134, 162, 196, 238, 288, 342, 418, 576};
  int pretab_t  [NB] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                         1, 1, 1, 1, 2, 2, 3, 3, 3, 2, 0};

  logic [3:0]         sf_mem [NB];
  logic signed [15:0] coef_mem [NC];

  int cfg_gg;
  bit cfg_ss;
  bit cfg_pre;

  int cyc = 0;
  int start_cyc = 0;
  bit mon_en = 1'b0;
  int rdy_mode = 1;
  int rdy_pct = 100;

  int k, issued, pops, done_cnt, done_rel, busy_at_done, busy_rel1;
  int first_sf, first_cr, last_cr, first_valid, last_hs;
  int obs_exp [NB];
  bit prev_stall;
  logic [31:0] held;
  int rel;

  vec_t vecs [5];

  dequant_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .global_gain    (global_gain),
    .scalefac_scale (scalefac_scale),
    .preflag        (preflag),
    .busy           (busy),
    .done           (done),
    .sf_ren         (sf_ren),
    .sf_raddr       (sf_raddr),
    .sf_rdata       (sf_rdata),
    .coef_ren       (coef_ren),
    .coef_raddr     (coef_raddr),
    .coef_rdata     (coef_rdata),
    .dq_valid       (dq_valid),
    .dq_ready       (dq_ready),
    .dq_is          (dq_is),
    .dq_exp         (dq_exp),
    .dq_sfb         (dq_sfb),
    .dq_last        (dq_last)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter advanced on each rising edge.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference expected exponent for a band, straight from the gain formula.
  function automatic int modelExp(input int b);
    int eff;
    eff = (b == NB - 1) ? 0 : int'(sf_mem[b]) + (cfg_pre ? pretab_t[b] : 0);
    return cfg_gg - 210 - eff * (cfg_ss ? 4 : 2);
  endfunction

  function automatic int bandOf(input int idx);
    for (int b = 0; b < NB; b++) begin
      if (idx < sfb_end_t[b]) return b;
    end
    return NB - 1;
  endfunction

  task automatic checkOutput(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Scalefactor and coefficient memories with one-cycle read latency.
  initial forever begin
    logic       s_ren;
    logic [4:0] s_a;
    logic       c_ren;
    logic [9:0] c_a;
    @(negedge clk);
    s_ren = sf_ren;
    s_a   = sf_raddr;
    c_ren = coef_ren;
    c_a   = coef_raddr;
    @(posedge clk);
    #1;
    sf_rdata   = s_ren ? sf_mem[s_a] : 4'($urandom);
    coef_rdata = c_ren ? coef_mem[c_a] : 16'($urandom);
  end

  // Dequantizer ready: held low, held high, or random with a given percentage.
  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_mode == 0) dq_ready = 1'b0;
    else if (rdy_mode == 1) dq_ready = 1'b1;
    else dq_ready = ($urandom_range(0, 99) < rdy_pct);
  end

  // Output monitor: scoreboard, stall stability, outstanding reads, timing marks.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      rel = cyc - start_cyc;
      if (rel == 1) busy_rel1 = busy;
      if (sf_ren && first_sf < 0) first_sf = rel;
      if (dq_valid && first_valid < 0) first_valid = rel;
      if (prev_stall) begin
        checkOutput(dq_valid == 1'b1, "hold_valid", dq_valid, 1);
        checkOutput({dq_is, dq_exp, dq_sfb, dq_last} == held, "hold_data",
                    {dq_is, dq_exp, dq_sfb, dq_last}, held);
      end
      checkOutput(issued - pops <= 2, "outstanding", issued - pops, 2);
      if (dq_valid && dq_ready) begin
        checkOutput(k < NC, "entry_count", k, NC - 1);
        if (k < NC) begin
          checkOutput(dq_is == coef_mem[k], "dq_is", dq_is, coef_mem[k]);
          checkOutput(int'(dq_exp) == modelExp(bandOf(k)), "dq_exp", dq_exp, modelExp(bandOf(k)));
          checkOutput(int'(dq_sfb) == bandOf(k), "dq_sfb", dq_sfb, bandOf(k));
          checkOutput(dq_last == (k == NC - 1), "dq_last", dq_last, (k == NC - 1));
        end
        if (dq_sfb < NB) obs_exp[dq_sfb] = int'(dq_exp);
        if (dq_last) last_hs = rel;
        k++;
        pops++;
      end
      if (coef_ren) begin
        issued++;
        if (first_cr < 0) first_cr = rel;
        last_cr = rel;
      end
      if (done) begin
        done_cnt++;
        done_rel = rel;
        busy_at_done = busy;
      end
      prev_stall = dq_valid && !dq_ready;
      held = {dq_is, dq_exp, dq_sfb, dq_last};
    end
  end

  // Fills memories, records the configuration and pulses start.
  task automatic applyStimulus(input int gg, input bit ss, input bit pre, input int sfmode);
    for (int b = 0; b < NB; b++) begin
      case (sfmode)
        0: sf_mem[b] = 4'd0;
        1: sf_mem[b] = (b == 11) ? 4'd3 : 4'd0;
        2: sf_mem[b] = 4'd15;
        default: sf_mem[b] = 4'($urandom_range(0, 15));
      endcase
      obs_exp[b] = -9999;
    end
    for (int i = 0; i < NC; i++) coef_mem[i] = 16'($urandom);
    cfg_gg = gg;
    cfg_ss = ss;
    cfg_pre = pre;
    k = 0; issued = 0; pops = 0; done_cnt = 0; done_rel = -1; busy_at_done = -1;
    busy_rel1 = -1; first_sf = -1; first_cr = -1; last_cr = -1; first_valid = -1;
    last_hs = -1; prev_stall = 1'b0;
    @(posedge clk);
    #1;
    global_gain = 8'(gg);
    scalefac_scale = ss;
    preflag = pre;
    start = 1'b1;
    start_cyc = cyc;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    global_gain = 8'($urandom);
    scalefac_scale = 1'($urandom);
    preflag = 1'($urandom);
  endtask

  task automatic waitDone(input int limit);
    int n = 0;
    while (done_cnt == 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    checkOutput(done_cnt == 1, "done_count", done_cnt, 1);
    checkOutput(k == NC, "entries", k, NC);
    mon_en = 1'b0;
  endtask

  task automatic checkTiming();
    checkOutput(busy_rel1 == 1, "t_busy_c1", busy_rel1, 1);
    checkOutput(first_sf == 1, "t_first_sf_ren", first_sf, 1);
    checkOutput(first_cr == 3, "t_first_coef_ren", first_cr, 3);
    checkOutput(first_valid == 5, "t_first_valid", first_valid, 5);
    checkOutput(last_cr == 620, "t_last_coef_ren", last_cr, 620);
    checkOutput(last_hs == 622, "t_last_handshake", last_hs, 622);
    checkOutput(done_rel == 623, "t_done", done_rel, 623);
    checkOutput(busy_at_done == 0, "t_busy_at_done", busy_at_done, 0);
  endtask

  task automatic checkResetOutputs();
    checkOutput(busy == 1'b0, "rst_busy", busy, 0);
    checkOutput(done == 1'b0, "rst_done", done, 0);
    checkOutput(sf_ren == 1'b0, "rst_sf_ren", sf_ren, 0);
    checkOutput(coef_ren == 1'b0, "rst_coef_ren", coef_ren, 0);
    checkOutput(dq_valid == 1'b0, "rst_dq_valid", dq_valid, 0);
    checkOutput(dq_last == 1'b0, "rst_dq_last", dq_last, 0);
    checkOutput(sf_raddr == 5'd0, "rst_sf_raddr", sf_raddr, 0);
    checkOutput(coef_raddr == 10'd0, "rst_coef_raddr", coef_raddr, 0);
    checkOutput(dq_is == 16'sd0, "rst_dq_is", dq_is, 0);
    checkOutput(dq_exp == 10'sd0, "rst_dq_exp", dq_exp, 0);
    checkOutput(dq_sfb == 5'd0, "rst_dq_sfb", dq_sfb, 0);
  endtask

  task automatic runVector(input vec_t v);
    rdy_mode = v.rmode;
    rdy_pct = v.pct;
    applyStimulus(v.gg, v.ss, v.pre, v.sfmode);
    waitDone(5000);
    if (v.exp_band >= 0) begin
      checkOutput(obs_exp[v.exp_band] == v.exp_val, "band_exp", obs_exp[v.exp_band], v.exp_val);
    end
    if (v.timing) checkTiming();
  endtask

  // Main sequence.
  initial begin
    vecs[0] = '{gg: 210, ss: 0, pre: 0, sfmode: 0, rmode: 1, pct: 100, exp_band: 11, exp_val: 0,    timing: 1};
    vecs[1] = '{gg: 200, ss: 1, pre: 1, sfmode: 1, rmode: 1, pct: 100, exp_band: 11, exp_val: -26,  timing: 1};
    vecs[2] = '{gg: 255, ss: 0, pre: 1, sfmode: 2, rmode: 2, pct: 30,  exp_band: 21, exp_val: 45,   timing: 0};
    vecs[3] = '{gg: 0,   ss: 1, pre: 1, sfmode: 2, rmode: 2, pct: 70,  exp_band: 17, exp_val: -282, timing: 0};
    vecs[4] = '{gg: 137, ss: 1, pre: 0, sfmode: 3, rmode: 2, pct: 50,  exp_band: -1, exp_val: 0,    timing: 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetOutputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 5; i++) begin
      $display("[TB] granule vector %0d", i);
      runVector(vecs[i]);
    end

    $display("[TB] ready held low after first valid");
    rdy_mode = 0;
    applyStimulus(180, 0, 1, 3);
    for (int n = 0; n < 100 && first_valid < 0; n++) begin
      @(posedge clk);
      #1;
    end
    checkOutput(first_valid == 5, "stall_first_valid", first_valid, 5);
    repeat (50) @(posedge clk);
    #1;
    checkOutput(issued == 2, "stall_reads", issued, 2);
    rdy_mode = 1;
    waitDone(3000);

    $display("[TB] start pulsed while busy");
    rdy_mode = 2;
    rdy_pct = 50;
    applyStimulus(210, 0, 0, 3);
    while (cyc < start_cyc + 100) begin
      @(posedge clk);
      #1;
    end
    global_gain = 8'd99;
    scalefac_scale = 1'b1;
    preflag = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(5000);

    $display("[TB] reset mid-granule");
    rdy_mode = 1;
    applyStimulus(210, 0, 0, 3);
    while (cyc < start_cyc + 300) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkResetOutputs();
    repeat (3) @(posedge clk);
    runVector(vecs[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
